nibble_adder_arbiter: RTL and testbench



---
 rtl/nibble_adder_arbiter.sv | 113 +++++++++++
 tb/tb_nibble_adder_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_adder_arbiter.sv
// Shared 16-bit add/sub built from one 4-bit slice; two requesters, round-robin.
// Accept-to-ack is 5 cycles, 1 op per 6 cycles; requests are only taken in IDLE.
module nibble_adder_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [15:0] a0,
   input  logic [15:0] b0,
   input  logic [15:0] a1,
   input  logic [15:0] b1,
   input  logic        sub0,
   input  logic        sub1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        ack0,
   output logic        ack1,
   output logic [15:0] sum,
   output logic        cout,
   output logic        ovf,
   output logic        done,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t      state;
   logic [1:0]  idx;
   logic        c;
   logic        last_gnt;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic [11:0] work;
   logic [3:0]  a_nib;
   logic [3:0]  b_nib;
   logic [3:0]  nib_sum;
   logic        nib_cout;
   logic        pick1;

   assign a_nib = a_q[{idx, 2'b00} +: 4];
   assign b_nib = b_q[{idx, 2'b00} +: 4];
   assign {nib_cout, nib_sum} = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, c};

   // On a tie the requester that did not win last time is served.
   assign pick1 = req1 & (~req0 | ~last_gnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= 2'd0;
         c        <= 1'b0;
         last_gnt <= 1'b1;
         a_q      <= 16'h0000;
         b_q      <= 16'h0000;
         work     <= 12'h000;
         sum      <= 16'h0000;
         cout     <= 1'b0;
         ovf      <= 1'b0;
         done     <= 1'b0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  a_q      <= pick1 ? a1 : a0;
                  b_q      <= pick1 ? (sub1 ? ~b1 : b1) : (sub0 ? ~b0 : b0);
                  c        <= pick1 ? sub1 : sub0;
                  gnt0     <= ~pick1;
                  gnt1     <= pick1;
                  last_gnt <= pick1;
                  idx      <= 2'd0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               c   <= nib_cout;
               idx <= idx + 2'd1;
               case (idx)
                  2'd0: work[3:0]  <= nib_sum;
                  2'd1: work[7:4]  <= nib_sum;
                  2'd2: work[11:8] <= nib_sum;
                  default: begin
                     // Top nibble goes straight into the result register.
                     sum   <= {nib_sum, work};
                     cout  <= nib_cout;
                     ovf   <= (a_q[15] == b_q[15]) && (nib_sum[3] != a_q[15]);
                     done  <= 1'b1;
                     ack0  <= gnt0;
                     ack1  <= gnt1;
                     state <= DONE;
                  end
               endcase
            end
            DONE: begin
               done  <= 1'b0;
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               gnt0  <= 1'b0;
               gnt1  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_adder_arbiter.sv
// Bench for nibble_adder_arbiter: vector table, ties, reset corners, random ops.
module tb_nibble_adder_arbiter;

   logic        clk = 1'b0;
   logic        rst, req0, req1, sub0, sub1;
   logic [15:0] a0, b0, a1, b1;
   logic        gnt0, gnt1, ack0, ack1, cout, ovf, done, busy;
   logic [15:0] sum;

   int checks = 0;
   int errors = 0;

   nibble_adder_arbiter dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sub0(sub0), .sub1(sub1),
      .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
      .sum(sum), .cout(cout), .ovf(ovf), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain unsigned/signed integer arithmetic on the whole word.
   task automatic model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        output logic [15:0] s, output logic co, output logic ov);
      int sa, sb, r;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sub) begin
         s  = a - b;
         co = (a >= b);
         r  = sa - sb;
      end else begin
         {co, s} = {1'b0, a} + {1'b0, b};
         r  = sa + sb;
      end
      ov = (r > 32767) || (r < -32768);
   endtask

   task automatic set_req(input int who, input logic v, input logic [15:0] a,
                          input logic [15:0] b, input logic sub);
      if (who == 0) begin
         req0 = v; a0 = a; b0 = b; sub0 = sub;
      end else begin
         req1 = v; a1 = a; b1 = b; sub1 = sub;
      end
   endtask

   task automatic do_reset();
      req0 = 1'b0; req1 = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Lone request; optional scramble changes operands and drops req after accept.
   task automatic run_op(input int who, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic scramble, input logic [15:0] es,
                         input logic ec, input logic eo, input string nm);
      int t_gnt, t_ack;
      t_gnt = -1;
      t_ack = -1;
      set_req(who, 1'b1, a, b, sub);
      for (int t = 1; t <= 12 && t_ack < 0; t++) begin
         tick();
         check({nm, "_gnt_excl"}, {31'd0, gnt0 & gnt1}, 32'd0);
         if (t_gnt < 0 && (who == 0 ? gnt0 : gnt1)) begin
            t_gnt = t;
            if (scramble) set_req(who, 1'b0, ~a, b ^ 16'h5A5A, ~sub);
         end
         if (ack0 | ack1) t_ack = t;
      end
      check({nm, "_gnt_lat"}, t_gnt, 32'd1);
      check({nm, "_ack_lat"}, t_ack, 32'd5);
      check({nm, "_ack_who"}, {30'd0, ack1, ack0}, (who == 0) ? 32'd1 : 32'd2);
      check({nm, "_done"}, {31'd0, done}, 32'd1);
      check({nm, "_sum"}, {16'd0, sum}, {16'd0, es});
      check({nm, "_cout_ovf"}, {30'd0, cout, ovf}, {30'd0, ec, eo});
      set_req(who, 1'b0, a, b, sub);
      tick();
      check({nm, "_idle"}, {27'd0, busy, done, ack0, ack1, gnt0 | gnt1}, 32'd0);
      check({nm, "_sum_hold"}, {16'd0, sum}, {16'd0, es});
   endtask

   initial begin
      logic [15:0] es, ra, rb;
      logic        ec, eo, rs, model_last, got;
      logic [15:0] opa[2];
      logic [15:0] opb[2];
      logic        ops[2];
      int          t_gnt, t_ack, who, done_seen;

      vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

      // Reset held with req0 already high.
      rst = 1'b1; req1 = 1'b0;
      a1 = 16'h0; b1 = 16'h0; sub1 = 1'b0;
      set_req(0, 1'b1, 16'h0001, 16'h0002, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("reset_outputs", {sum, 7'd0, gnt0, gnt1, ack0, ack1, cout, ovf, done, busy}, 32'd0);
      end
      rst = 1'b0;
      run_op(0, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, "post_reset");

      // Vector table; requester pattern 1,1,0,0,1,1,0 gives back-to-back lone req1.
      for (int i = 0; i < 7; i++) begin
         who = ((i >> 1) & 1) ^ 1;
         run_op(who, vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0,
                vecs[i].s, vecs[i].co, vecs[i].ov, $sformatf("vec%0d", i));
      end

      // Operands changed and req dropped after accept must not matter.
      run_op(0, 16'h1111, 16'h2222, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, "stable0");
      run_op(1, 16'h0100, 16'h0200, 1'b1, 1'b1, 16'hFF00, 1'b0, 1'b0, "stable1");

      // Repeated ties after reset: req0 first, then alternate.
      do_reset();
      model_last = 1'b1;
      for (int k = 0; k < 2; k++) begin
         opa[k] = 16'($urandom); opb[k] = 16'($urandom); ops[k] = 1'($urandom);
         set_req(k, 1'b1, opa[k], opb[k], ops[k]);
      end
      for (int r = 0; r < 6; r++) begin
         t_gnt = -1;
         got = 1'b0;
         for (int t = 1; t <= 8 && t_gnt < 0; t++) begin
            tick();
            check("tie_gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
            if (gnt0 | gnt1) begin
               t_gnt = t;
               got = gnt1;
            end
         end
         check("tie_gnt_lat", t_gnt, 32'd1);
         check("tie_winner", {31'd0, got}, {31'd0, ~model_last});
         model_last = ~model_last;
         who = int'(model_last);
         model(opa[who], opb[who], ops[who], es, ec, eo);
         t_ack = -1;
         for (int t = 1; t <= 8 && t_ack < 0; t++) begin
            tick();
            check("tie_gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
            if (ack0 | ack1) t_ack = t;
         end
         check("tie_ack_lat", t_ack, 32'd4);
         check("tie_ack_who", {30'd0, ack1, ack0}, (who == 0) ? 32'd1 : 32'd2);
         check("tie_sum", {15'd0, cout, sum}, {15'd0, ec, es});
         check("tie_ovf", {31'd0, ovf}, {31'd0, eo});
         set_req(who, 1'b0, opa[who], opb[who], ops[who]);
         tick();
         opa[who] = 16'($urandom); opb[who] = 16'($urandom); ops[who] = 1'($urandom);
         set_req(who, 1'b1, opa[who], opb[who], ops[who]);
      end

      // Reset with idx = 2 discards the operation.
      do_reset();
      set_req(1, 1'b1, 16'h00FF, 16'h0001, 1'b0);
      tick();
      tick();
      tick();
      check("midrst_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_req(1, 1'b0, 16'h00FF, 16'h0001, 1'b0);
      check("midrst_state", {sum, 9'd0, busy, done, ack0, ack1, gnt0 | gnt1, cout, ovf}, 32'd0);
      done_seen = 0;
      for (int t = 0; t < 8; t++) begin
         tick();
         if (done | ack0 | ack1) done_seen++;
      end
      check("midrst_no_done", done_seen, 32'd0);
      check("midrst_sum", {16'd0, sum}, 32'd0);
      run_op(1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "after_midrst");

      // Random lone operations against the integer model.
      for (int n = 0; n < 16; n++) begin
         ra = 16'($urandom);
         rb = (n % 4 == 0) ? ra : 16'($urandom);
         rs = 1'($urandom);
         model(ra, rb, rs, es, ec, eo);
         run_op(int'($urandom_range(1, 0)), ra, rb, rs, 1'($urandom), es, ec, eo,
                $sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
